// File: rtl/ifft_playback_buffer.sv
// Ping-pong frame buffer between the IFFT real output and the DAC. Each frame is captured,
// then played back in natural order, one sample every RATE_DIV clocks.
// `define BITREV_WADDR_EN to un-scramble bit-reversed IFFT output on write.
`timescale 1ns/1ps
module ifft_playback_buffer #(
  parameter int unsigned LOG2_FRAME = 10,
  parameter int unsigned IN_W       = 26,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned RATE_DIV   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [IN_W-1:0]   data_in,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_strobe,
  output logic              playing,
  output logic              overrun,
  output logic              underrun
);

  localparam int unsigned FRAME = 1 << LOG2_FRAME;
  localparam int unsigned DIV_W = $clog2(RATE_DIV);
  localparam int unsigned HI_W  = IN_W - SHIFT - DATA_W + 1;

  typedef enum logic {StIdle, StPlay} state_e;

  state_e                r_state, w_state_d;
  logic [LOG2_FRAME-1:0] r_wcount, r_rcount, w_waddr;
  logic [DIV_W-1:0]      r_div;
  logic                  r_wbank, r_rbank, r_pending;
  logic                  r_rd_valid, r_strobe, r_overrun, r_underrun;
  logic [DATA_W-1:0]     r_rdata, r_sample, w_sat;
  logic [DATA_W-1:0]     r_mem [2*FRAME];
  logic [HI_W-1:0]       w_hi;
  logic                  w_wr_en, w_wr_last, w_tick, w_final, w_have_frame, w_swap, w_end_empty;

  // The kept slice's sign bit must agree with every discarded upper bit.
  assign w_hi  = data_in[IN_W-1 -: HI_W];
  assign w_sat = ((w_hi == '0) || (w_hi == '1)) ? data_in[SHIFT +: DATA_W] :
                 data_in[IN_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};

`ifdef BITREV_WADDR_EN
  function automatic logic [LOG2_FRAME-1:0] bitrev(input logic [LOG2_FRAME-1:0] a);
    logic [LOG2_FRAME-1:0] r;
    for (int i = 0; i < LOG2_FRAME; i++) r[i] = a[LOG2_FRAME-1-i];
    return r;
  endfunction
  assign w_waddr = bitrev(r_wcount);
`else
  assign w_waddr = r_wcount;
`endif

  assign w_wr_en      = valid_in & ~r_pending;
  assign w_wr_last    = w_wr_en & (r_wcount == '1);
  assign w_tick       = (r_state == StPlay) & (r_div == '0);
  assign w_final      = w_tick & (r_rcount == '1);
  // A frame completing this very cycle counts as ready, so it can meet the reader's last tick.
  assign w_have_frame = r_pending | w_wr_last;
  assign w_swap       = w_have_frame & ((r_state == StIdle) | w_final);
  assign w_end_empty  = w_final & ~w_have_frame;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_swap) w_state_d = StPlay;
      StPlay:  if (w_end_empty) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_wcount   <= '0;
      r_rcount   <= '0;
      r_div      <= '0;
      r_wbank    <= 1'b0;
      r_rbank    <= 1'b0;
      r_pending  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_strobe   <= 1'b0;
      r_sample   <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_have_frame & ~w_swap;
      if (w_wr_en) r_wcount <= r_wcount + LOG2_FRAME'(1);
      if (w_swap) begin
        r_rbank  <= r_wbank;
        r_wbank  <= ~r_wbank;
        r_rcount <= '0;
        r_div    <= '0;
      end else if (r_state == StPlay) begin
        if (w_end_empty || r_div == DIV_W'(RATE_DIV-1)) r_div <= '0;
        else r_div <= r_div + DIV_W'(1);
        if (w_tick) r_rcount <= r_rcount + LOG2_FRAME'(1);
      end
      r_rd_valid <= w_tick;
      r_strobe   <= r_rd_valid;
      if (r_rd_valid) r_sample <= r_rdata;
      r_overrun  <= (valid_in & r_pending) | (r_overrun & ~clr_flags);
      r_underrun <= w_end_empty | (r_underrun & ~clr_flags);
    end
  end

  // Frame storage: both banks in one array, bank select as the address MSB; never reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[{r_wbank, w_waddr}] <= w_sat;
    r_rdata <= r_mem[{r_rbank, r_rcount}];
  end

  assign sample_out    = r_sample;
  assign sample_strobe = r_strobe;
  assign playing       = (r_state == StPlay);
  assign overrun       = r_overrun;
  assign underrun      = r_underrun;

endmodule

// File: tb/tb_ifft_playback_buffer.sv
// Directed bench for ifft_playback_buffer: capture, playback order/timing, saturation,
// overrun, seamless swap, underrun and mid-run reset.
`timescale 1ns/1ps
module tb_ifft_playback_buffer;

  localparam int LOG2_FRAME = 10;
  localparam int IN_W       = 26;
  localparam int DATA_W     = 16;
  localparam int SHIFT      = 0;
  localparam int RATE_DIV   = 4;
  localparam int FRAME      = 1 << LOG2_FRAME;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              valid_in = 1'b0;
  logic [IN_W-1:0]   data_in = '0;
  logic              clr_flags = 1'b0;
  logic [DATA_W-1:0] sample_out;
  logic              sample_strobe, playing, overrun, underrun;

  ifft_playback_buffer #(
    .LOG2_FRAME(LOG2_FRAME),
    .IN_W      (IN_W),
    .DATA_W    (DATA_W),
    .SHIFT     (SHIFT),
    .RATE_DIV  (RATE_DIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .clr_flags    (clr_flags),
    .sample_out   (sample_out),
    .sample_strobe(sample_strobe),
    .playing      (playing),
    .overrun      (overrun),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] q_val[$];
  int                q_cyc[$];
  always @(negedge clk) begin
    if (sample_strobe === 1'b1) begin
      q_val.push_back(sample_out);
      q_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write address the DUT uses for the i-th accepted sample of a frame.
  function automatic int addr_of(input int i);
`ifdef BITREV_WADDR_EN
    int r = 0;
    for (int b = 0; b < LOG2_FRAME; b++) if (i[b]) r |= 1 << (LOG2_FRAME - 1 - b);
    return r;
`else
    return i;
`endif
  endfunction

  task automatic do_reset();
    valid_in  = 1'b0;
    clr_flags = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    q_val.delete();
    q_cyc.delete();
  endtask

  // Writes one frame whose natural-order playback is base, base+1, ...
  task automatic write_frame(input int base, output int last_cyc);
    for (int i = 0; i < FRAME; i++) begin
      valid_in = 1'b1;
      data_in  = 26'(base + addr_of(i));
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int b = budget;
    while (q_val.size() < n && b > 0) begin
      @(posedge clk);
      b--;
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sample_out !== 16'h0000) begin errors++; $display("FAIL reset_sample_out: got %h want 0000", sample_out); end
    checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", sample_strobe); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b want 0", playing); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_playback();
    int p, first, nbad, gbad;
    do_reset();
    write_frame(0, p);
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL play_start: playing got %b want 1", playing); end
    wait_strobes(FRAME, FRAME * RATE_DIV + 100);
    checks++; if (q_val.size() != FRAME) begin errors++; $display("FAIL play_count: got %0d want %0d", q_val.size(), FRAME); end
    first = (q_cyc.size() > 0) ? q_cyc[0] : -1;
    checks++; if (first != p + 2) begin errors++; $display("FAIL play_latency: first strobe cycle %0d want %0d", first, p + 2); end
    nbad = 0; gbad = 0;
    for (int k = 0; k < FRAME; k++) if (k >= q_val.size() || q_val[k] !== 16'(k)) nbad++;
    for (int k = 1; k < q_cyc.size(); k++) if (q_cyc[k] - q_cyc[k-1] != RATE_DIV) gbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL play_order: %0d wrong samples, want 0", nbad); end
    checks++; if (gbad != 0) begin errors++; $display("FAIL play_interval: %0d gaps not %0d clocks", gbad, RATE_DIV); end
    repeat (3 * RATE_DIV + 10) @(posedge clk);
    #1;
    checks++; if (q_val.size() != FRAME) begin errors++; $display("FAIL idle_no_strobe: strobes %0d want %0d", q_val.size(), FRAME); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL end_playing: got %b want 0", playing); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL end_underrun: got %b want 1", underrun); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL end_overrun: got %b want 0", overrun); end
    clr_flags = 1'b1;
    @(posedge clk);
    #1 clr_flags = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clr_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_saturation();
    logic [IN_W-1:0]   sin [6];
    logic [DATA_W-1:0] sexp [6];
    sin[0] = 26'h0010000; sexp[0] = 16'h7FFF;
    sin[1] = 26'h3FF0000; sexp[1] = 16'h8000;
    sin[2] = 26'h3FFFFFF; sexp[2] = 16'hFFFF;
    sin[3] = 26'h0001234; sexp[3] = 16'h1234;
    sin[4] = 26'h3FF8000; sexp[4] = 16'h8000;
    sin[5] = 26'h0007FFF; sexp[5] = 16'h7FFF;
    do_reset();
    for (int i = 0; i < FRAME; i++) begin
      valid_in = 1'b1;
      data_in  = (i < 6) ? sin[i] : 26'h0000005;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    wait_strobes(FRAME, FRAME * RATE_DIV + 100);
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (q_val.size() != FRAME || q_val[addr_of(j)] !== sexp[j]) begin
        errors++;
        $display("FAIL sat_%0d: got %h want %h", j,
                 (q_val.size() == FRAME) ? q_val[addr_of(j)] : 16'h0, sexp[j]);
      end
    end
  endtask

  task automatic test_overrun_seamless();
    int pa, pb, nbad, gbad;
    do_reset();
    write_frame(0, pa);
    write_frame(16'h4000, pb);
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      data_in  = 26'h0000777;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    // Clear and a new drop in the same cycle: the set must win.
    valid_in = 1'b1; clr_flags = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0; clr_flags = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins: got %b want 1", overrun); end
    clr_flags = 1'b1;
    @(posedge clk);
    #1 clr_flags = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b want 0", overrun); end
    wait_strobes(FRAME + 1, FRAME * RATE_DIV + 100);
    checks++; if (underrun !== 1'b0 || playing !== 1'b1) begin errors++; $display("FAIL ab_transition: underrun %b playing %b want 0 1", underrun, playing); end
    wait_strobes(2 * FRAME, FRAME * RATE_DIV + 100);
    nbad = 0; gbad = 0;
    for (int k = 0; k < 2 * FRAME; k++)
      if (k >= q_val.size() || q_val[k] !== ((k < FRAME) ? 16'(k) : 16'(16'h4000 + k - FRAME))) nbad++;
    for (int k = 1; k < q_cyc.size(); k++) if (q_cyc[k] - q_cyc[k-1] > RATE_DIV) gbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL ab_order: %0d wrong samples, want 0", nbad); end
    checks++; if (gbad != 0) begin errors++; $display("FAIL ab_gap: %0d gaps over %0d clocks", gbad, RATE_DIV); end
    repeat (RATE_DIV + 10) @(posedge clk);
    #1;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL b_end_underrun: got %b want 1", underrun); end
  endtask

  task automatic test_back_to_back();
    int pa, pb, nbad, tgap;
    do_reset();
    write_frame(16'h1000, pa);
    // Last write of B lands on the clock the reader issues A's final tick.
    repeat ((RATE_DIV - 1) * (FRAME - 1)) @(posedge clk);
    #1;
    write_frame(16'h5000, pb);
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL exact_playing: got %b want 1", playing); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL exact_underrun: got %b want 0", underrun); end
    wait_strobes(2 * FRAME, 2 * FRAME * RATE_DIV + 100);
    nbad = 0;
    for (int k = 0; k < 2 * FRAME; k++)
      if (k >= q_val.size() || q_val[k] !== ((k < FRAME) ? 16'(16'h1000 + k) : 16'(16'h5000 + k - FRAME))) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL exact_order: %0d wrong samples, want 0", nbad); end
    tgap = (q_cyc.size() > FRAME) ? q_cyc[FRAME] - q_cyc[FRAME-1] : -1;
    checks++; if (tgap != 1) begin errors++; $display("FAIL exact_gap: got %0d clocks want 1", tgap); end
  endtask

  task automatic test_reset_midway();
    int pa, pc, nbad;
    logic [DATA_W-1:0] exp_last;
    do_reset();
    write_frame(16'h0100, pa);
    wait_strobes(10, 100);
    for (int i = 0; i < 500; i++) begin
      valid_in = 1'b1;
      data_in  = 26'(16'h2000 + i);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    exp_last = 16'(16'h0100 + q_val.size() - 1);
    checks++; if (sample_out !== exp_last) begin errors++; $display("FAIL pre_reset_sample: got %h want %h", sample_out, exp_last); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (sample_out !== 16'h0000 || sample_strobe !== 1'b0) begin errors++; $display("FAIL midreset_data: sample %h strobe %b want 0000 0", sample_out, sample_strobe); end
    checks++; if (playing !== 1'b0 || overrun !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL midreset_status: %b%b%b want 000", playing, overrun, underrun); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    q_val.delete();
    q_cyc.delete();
    write_frame(16'h3000, pc);
    wait_strobes(FRAME, FRAME * RATE_DIV + 100);
    checks++; if (q_cyc.size() == 0 || q_cyc[0] != pc + 2) begin errors++; $display("FAIL post_reset_latency: got %0d want %0d", (q_cyc.size() > 0) ? q_cyc[0] : -1, pc + 2); end
    nbad = 0;
    for (int k = 0; k < FRAME; k++) if (k >= q_val.size() || q_val[k] !== 16'(16'h3000 + k)) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL post_reset_order: %0d wrong samples, want 0", nbad); end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_saturation();
    test_overrun_seamless();
    test_back_to_back();
    test_reset_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
